stamp_commit_queue: RTL and testbench

In-order commit buffer for the stamp conveyor. The issue stage allocates a stamp (tag) per instruction in program order. The ALU posts results against stamps in any order. This block is the reader end: it releases results to the register-file write port (rd address, data, write strobe) strictly in allocation order, one per cycle, so out-of-order completions retire in program order.

---
 rtl/stamp_commit_queue.sv | 144 ++++++++++++++
 tb/tb_stamp_commit_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stamp_commit_queue.sv
// In-order commit buffer: allocates stamps in program order, accepts completions in any
// order, retires results in allocation order. Define CPL_BYPASS_EN for 1-cycle head bypass.
module stamp_commit_queue #(
   parameter int TAG_W  = 3,
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alloc_req,
   input  logic [RD_W-1:0]       alloc_rd,
   output logic                  alloc_gnt,
   output logic [TAG_W-1:0]      alloc_tag,
   input  logic                  cpl_valid,
   input  logic [TAG_W-1:0]      cpl_tag,
   input  logic [DATA_W-1:0]     cpl_data,
   output logic                  commit_valid,
   output logic [RD_W-1:0]       commit_rd,
   output logic [DATA_W-1:0]     commit_data,
   output logic [TAG_W-1:0]      commit_tag,
   output logic [2**TAG_W-1:0]   pending_flat,
   output logic [TAG_W:0]        count,
   output logic                  cpl_err
);

   localparam int DEPTH = 2**TAG_W;
   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [TAG_W:0]    count_q, count_d;
   logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
   logic [RD_W-1:0]   rd_q   [DEPTH];
   logic [RD_W-1:0]   rd_d   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic              commit_valid_q, commit_valid_d;
   logic [RD_W-1:0]   commit_rd_q, commit_rd_d;
   logic [DATA_W-1:0] commit_data_q, commit_data_d;
   logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
   logic              cpl_err_q, cpl_err_d;

   logic              alloc_fire, cpl_ok, commit_fire;
   logic [DATA_W-1:0] commit_src;

   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      head_d         = head_q;
      tail_d         = tail_q;
      valid_d        = valid_q;
      done_d         = done_q;
      rd_d           = rd_q;
      data_d         = data_q;
      commit_valid_d = 1'b0;
      commit_rd_d    = commit_rd_q;
      commit_data_d  = commit_data_q;
      commit_tag_d   = commit_tag_q;
      cpl_err_d      = cpl_err_q;

      alloc_fire = alloc_req && (count_q != FULL_CNT);
      // The tail slot is never valid while not full, so a completion racing its own
      // allocation fails this check and is flagged as an error.
      cpl_ok     = cpl_valid && valid_q[cpl_tag] && !done_q[cpl_tag];
`ifdef CPL_BYPASS_EN
      commit_fire = (cpl_ok && (cpl_tag == head_q)) || (valid_q[head_q] && done_q[head_q]);
      commit_src  = done_q[head_q] ? data_q[head_q] : cpl_data;
`else
      commit_fire = valid_q[head_q] && done_q[head_q];
      commit_src  = data_q[head_q];
`endif

      if (alloc_fire) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q]  = 1'b0;
         rd_d[tail_q]    = alloc_rd;
         tail_d          = tail_q + TAG_W'(1);
      end

      if (cpl_valid) begin
         if (cpl_ok) begin
            done_d[cpl_tag] = 1'b1;
            data_d[cpl_tag] = cpl_data;
         end else begin
            cpl_err_d = 1'b1;
         end
      end

      // Clearing the head last also covers a bypassed completion, which never shows as done.
      if (commit_fire) begin
         commit_valid_d  = 1'b1;
         commit_rd_d     = rd_q[head_q];
         commit_data_d   = commit_src;
         commit_tag_d    = head_q;
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
         head_d          = head_q + TAG_W'(1);
      end

      count_d = count_q + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, commit_fire};
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         valid_q        <= '0;
         done_q         <= '0;
         commit_valid_q <= 1'b0;
         commit_rd_q    <= '0;
         commit_data_q  <= '0;
         commit_tag_q   <= '0;
         cpl_err_q      <= 1'b0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         valid_q        <= valid_d;
         done_q         <= done_d;
         commit_valid_q <= commit_valid_d;
         commit_rd_q    <= commit_rd_d;
         commit_data_q  <= commit_data_d;
         commit_tag_q   <= commit_tag_d;
         cpl_err_q      <= cpl_err_d;
      end
   end

   // NOTE: payload storage is not reset; valid/done gate every read, so stale contents are harmless.
   always_ff @(posedge clk) begin
      rd_q   <= rd_d;
      data_q <= data_d;
   end

   assign alloc_gnt    = (count_q != FULL_CNT);
   assign alloc_tag    = tail_q;
   assign commit_valid = commit_valid_q;
   assign commit_rd    = commit_rd_q;
   assign commit_data  = commit_data_q;
   assign commit_tag   = commit_tag_q;
   assign pending_flat = valid_q;
   assign count        = count_q;
   assign cpl_err      = cpl_err_q;

endmodule

// File: tb/tb_stamp_commit_queue.sv
// Directed bench for stamp_commit_queue: expected commits are queued when completions are
// driven and popped whenever the DUT raises commit_valid. Works with or without CPL_BYPASS_EN.
module tb_stamp_commit_queue;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [2:0]  tag;
   } commit_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        alloc_req;
   logic [4:0]  alloc_rd;
   logic        alloc_gnt;
   logic [2:0]  alloc_tag;
   logic        cpl_valid;
   logic [2:0]  cpl_tag;
   logic [31:0] cpl_data;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_data;
   logic [2:0]  commit_tag;
   logic [7:0]  pending_flat;
   logic [3:0]  count;
   logic        cpl_err;

   commit_t sb[$];
   int tests = 0;
   int fails = 0;

   stamp_commit_queue dut (
      .clk(clk), .reset(reset),
      .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
      .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
      .commit_tag(commit_tag), .pending_flat(pending_flat), .count(count), .cpl_err(cpl_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then score any commit against the front of the queue.
   task automatic tick();
      commit_t e;
      @(posedge clk);
      #1;
      if (commit_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_commit", 64'(commit_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            check("commit_rd",   64'(commit_rd),   64'(e.rd));
            check("commit_data", 64'(commit_data), 64'(e.data));
            check("commit_tag",  64'(commit_tag),  64'(e.tag));
         end
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      alloc_req = 1'b0;
      cpl_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] rd, input logic [2:0] exp_tag);
      alloc_req = 1'b1;
      alloc_rd  = rd;
      check("alloc_gnt", 64'(alloc_gnt), 64'd1);
      check("alloc_tag", 64'(alloc_tag), 64'(exp_tag));
      tick();
      alloc_req = 1'b0;
   endtask

   task automatic complete(input logic [2:0] tag, input logic [31:0] data);
      cpl_valid = 1'b1;
      cpl_tag   = tag;
      cpl_data  = data;
      tick();
      cpl_valid = 1'b0;
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic [2:0] tag);
      commit_t e;
      e.rd = rd; e.data = data; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (sb.size() > 0 && k < budget) begin
         tick();
         k++;
      end
      check("drain_budget", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      alloc_rd = '0; cpl_tag = '0; cpl_data = '0;
      do_reset();
      tick();
      check("rst_commit_valid", 64'(commit_valid), 64'd0);
      check("rst_commit_data",  64'(commit_data),  64'd0);
      check("rst_pending",      64'(pending_flat), 64'd0);
      check("rst_count",        64'(count),        64'd0);
      check("rst_cpl_err",      64'(cpl_err),      64'd0);
      check("rst_alloc_tag",    64'(alloc_tag),    64'd0);

      // 1: three allocations
      for (int i = 0; i < 3; i++) alloc(5'(i + 1), 3'(i));
      check("t1_count",   64'(count),        64'd3);
      check("t1_pending", 64'(pending_flat), 64'h07);
      check("t1_commit",  64'(commit_valid), 64'd0);

      // 2: out-of-order completion, in-order back-to-back retire
      complete(3'd2, 32'hC);
      check("t2_hold_a", 64'(commit_valid), 64'd0);
      complete(3'd1, 32'hB);
      check("t2_hold_b", 64'(commit_valid), 64'd0);
      push(5'd1, 32'hA, 3'd0);
      push(5'd2, 32'hB, 3'd1);
      push(5'd3, 32'hC, 3'd2);
      complete(3'd0, 32'hA);
`ifdef CPL_BYPASS_EN
      check("t2_first", 64'(commit_valid), 64'd1);
      for (int i = 0; i < 2; i++) begin
`else
      check("t2_first", 64'(commit_valid), 64'd0);
      for (int i = 0; i < 3; i++) begin
`endif
         tick();
         check("t2_b2b", 64'(commit_valid), 64'd1);
      end
      tick();
      check("t2_idle",     64'(commit_valid), 64'd0);
      check("t2_count",    64'(count),        64'd0);
      check("t2_hold_tag", 64'(commit_tag),   64'd2);
      check("t2_hold_rd",  64'(commit_rd),    64'd3);

      // 3: fill, drop when full, wrap
      do_reset();
      for (int i = 0; i < 8; i++) alloc(5'(i + 8), 3'(i));
      check("t3_count_full", 64'(count),        64'd8);
      check("t3_gnt_full",   64'(alloc_gnt),    64'd0);
      check("t3_pending",    64'(pending_flat), 64'hFF);
      alloc_req = 1'b1; alloc_rd = 5'd31;
      tick();
      alloc_req = 1'b0;
      check("t3_drop_count", 64'(count),     64'd8);
      check("t3_drop_tail",  64'(alloc_tag), 64'd0);
      push(5'd8, 32'h100, 3'd0);
      complete(3'd0, 32'h100);
`ifndef CPL_BYPASS_EN
      check("t3_still_full", 64'(alloc_gnt), 64'd0);
      tick();
`endif
      check("t3_commit",    64'(commit_valid), 64'd1);
      check("t3_count7",    64'(count),        64'd7);
      check("t3_gnt_back",  64'(alloc_gnt),    64'd1);
      alloc(5'd20, 3'd0);
      check("t3_refull",    64'(count),        64'd8);
      // full blocks an alloc even when a commit retires in the same cycle
      push(5'd9, 32'h101, 3'd1);
`ifdef CPL_BYPASS_EN
      cpl_valid = 1'b1; cpl_tag = 3'd1; cpl_data = 32'h101;
      alloc_req = 1'b1; alloc_rd = 5'd21;
      tick();
      cpl_valid = 1'b0; alloc_req = 1'b0;
`else
      complete(3'd1, 32'h101);
      alloc_req = 1'b1; alloc_rd = 5'd21;
      tick();
      alloc_req = 1'b0;
`endif
      check("t3_blk_commit", 64'(commit_valid), 64'd1);
      check("t3_blk_count",  64'(count),        64'd7);
      check("t3_blk_tail",   64'(alloc_tag),    64'd1);
      check("t3_blk_pend",   64'(pending_flat), 64'hFD);

      // 4a: double completion of one entry
      do_reset();
      alloc(5'd4, 3'd0);
      push(5'd4, 32'h77, 3'd0);
      complete(3'd0, 32'h77);
      check("t4_good_err", 64'(cpl_err), 64'd0);
      complete(3'd0, 32'h88);
      check("t4_dup_err",  64'(cpl_err), 64'd1);
      drain(3);
      // 4b: completion to an empty queue, sticky
      do_reset();
      complete(3'd5, 32'h1);
      check("t4_empty_err", 64'(cpl_err), 64'd1);
      for (int i = 0; i < 3; i++) tick();
      check("t4_sticky",    64'(cpl_err),      64'd1);
      check("t4_no_commit", 64'(commit_valid), 64'd0);
      // 4c: completion to the tail being allocated this cycle
      do_reset();
      alloc_req = 1'b1; alloc_rd = 5'd2;
      cpl_valid = 1'b1; cpl_tag = 3'd0; cpl_data = 32'h9;
      tick();
      alloc_req = 1'b0; cpl_valid = 1'b0;
      check("t4_tail_err",   64'(cpl_err), 64'd1);
      check("t4_tail_count", 64'(count),   64'd1);
      tick();
      check("t4_tail_nocommit", 64'(commit_valid), 64'd0);

      // 5: asynchronous reset mid-operation
      do_reset();
      for (int i = 0; i < 5; i++) alloc(5'(i + 1), 3'(i));
      push(5'd1, 32'h10, 3'd0);
      complete(3'd0, 32'h10);
      drain(3);
      complete(3'd2, 32'h12);
      complete(3'd3, 32'h13);
      check("t5_pending", 64'(pending_flat), 64'h1E);
      check("t5_count",   64'(count),        64'd4);
      reset = 1'b1;
      #2;
      check("t5_async_rd",    64'(commit_rd),    64'd0);
      check("t5_async_data",  64'(commit_data),  64'd0);
      check("t5_async_pend",  64'(pending_flat), 64'd0);
      check("t5_async_count", 64'(count),        64'd0);
      check("t5_async_tail",  64'(alloc_tag),    64'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_quiet", 64'(commit_valid), 64'd0);
      end

      // 6: completion-to-commit latency
      alloc(5'd7, 3'd0);
      push(5'd7, 32'h55, 3'd0);
      complete(3'd0, 32'h55);
`ifdef CPL_BYPASS_EN
      check("t6_lat1", 64'(commit_valid), 64'd1);
`else
      check("t6_lat_n",  64'(commit_valid), 64'd0);
      tick();
      check("t6_lat_n1", 64'(commit_valid), 64'd1);
`endif
      check("t6_data", 64'(commit_data), 64'h55);

      tick();
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
